// File: rtl/xaddr_router.sv
// Registered address router: decodes one master access onto N_SLV base/mask slave ports,
// waits for the selected slave's ready, aborts on timeout and records the first faulting address.
module xaddr_router #(
  parameter int                        ADDR_W   = 12,
  parameter int                        DATA_W   = 32,
  parameter int                        N_SLV    = 4,
  parameter logic [N_SLV*ADDR_W-1:0]   BASE_VEC = '0,
  parameter logic [N_SLV*ADDR_W-1:0]   MASK_VEC = '0,
  parameter int                        TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sel,
  input  logic [ADDR_W-1:0]         addr,
  output logic                      rdy,
  output logic [DATA_W-1:0]         data_to_rd,
  output logic [N_SLV-1:0]          slv_sel,
  input  logic [N_SLV-1:0]          slv_rdy,
  input  logic [N_SLV*DATA_W-1:0]   slv_rdata,
  output logic                      trap,
  output logic                      err,
  output logic [ADDR_W-1:0]         err_addr,
  input  logic                      err_clr
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_FAULT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [N_SLV-1:0]    r_slv_sel;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_err;
  logic [ADDR_W-1:0]   r_err_addr;

  logic [N_SLV-1:0]    w_hit_oh;
  logic                w_hit;
  logic                w_sel_rdy;
  logic [DATA_W-1:0]   w_rdata;

  // Scan from the top down so the lowest matching index ends up selected.
  always_comb begin
    w_hit_oh = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr & MASK_VEC[i*ADDR_W +: ADDR_W]) ==
          (BASE_VEC[i*ADDR_W +: ADDR_W] & MASK_VEC[i*ADDR_W +: ADDR_W])) begin
        w_hit_oh    = '0;
        w_hit_oh[i] = 1'b1;
      end
    end
  end

  assign w_hit     = |w_hit_oh;
  assign w_sel_rdy = |(slv_rdy & r_slv_sel);

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      w_rdata = w_rdata | (slv_rdata[i*DATA_W +: DATA_W] & {DATA_W{r_slv_sel[i]}});
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (sel) w_state_nxt = w_hit ? S_ACCESS : S_FAULT;
      end
      S_ACCESS: begin
        // Ready takes priority over the timeout limit in the same cycle.
        if (w_sel_rdy)                              w_state_nxt = S_RESP;
        else if ((TIMEOUT != 0) && (r_cnt == CNT_LIM)) w_state_nxt = S_FAULT;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      S_FAULT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_slv_sel  <= '0;
      r_cnt      <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (sel) begin
          r_addr    <= addr;
          r_slv_sel <= w_hit_oh;
        end
      end else if (r_state == S_ACCESS) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_sel_rdy) r_data <= w_rdata;
        if (w_state_nxt != S_ACCESS) r_slv_sel <= '0;
      end

      // A fault in the same cycle as a clear re-arms with the new address.
      if (r_state == S_FAULT) begin
        r_err <= 1'b1;
        if (!r_err || err_clr) r_err_addr <= r_addr;
      end else if (err_clr) begin
        r_err      <= 1'b0;
        r_err_addr <= '0;
      end
    end
  end

  assign rdy        = (r_state == S_RESP) || (r_state == S_FAULT);
  assign trap       = (r_state == S_FAULT);
  assign data_to_rd = (r_state == S_FAULT) ? '0 : r_data;
  assign slv_sel    = r_slv_sel;
  assign err        = r_err;
  assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_xaddr_router.sv
// Directed and randomized bench for xaddr_router against a rule-level decode and error model.
module tb_xaddr_router;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 15;
  localparam logic [NS*AW-1:0] BV = {12'h800, 12'h410, 12'h400, 12'h000};
  localparam logic [NS*AW-1:0] MV = {12'h800, 12'hFFF, 12'hFF0, 12'hC00};

  logic [AW-1:0] base_a [NS] = '{12'h000, 12'h400, 12'h410, 12'h800};
  logic [AW-1:0] mask_a [NS] = '{12'hC00, 12'hFF0, 12'hFFF, 12'h800};

  logic              clk;
  logic              rst_n;
  logic              sel;
  logic [AW-1:0]     addr;
  logic              rdy;
  logic [DW-1:0]     data_to_rd;
  logic [NS-1:0]     slv_sel;
  logic [NS-1:0]     slv_rdy;
  logic [NS*DW-1:0]  slv_rdata;
  logic              trap;
  logic              err;
  logic [AW-1:0]     err_addr;
  logic              err_clr;

  int checks = 0;
  int errors = 0;
  bit            m_err = 0;
  logic [AW-1:0] m_err_addr = '0;

  xaddr_router #(
    .ADDR_W(AW), .DATA_W(DW), .N_SLV(NS),
    .BASE_VEC(BV), .MASK_VEC(MV), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .rdy(rdy),
    .data_to_rd(data_to_rd), .slv_sel(slv_sel), .slv_rdy(slv_rdy),
    .slv_rdata(slv_rdata), .trap(trap), .err(err), .err_addr(err_addr),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_a[i]) == (base_a[i] & mask_a[i])) return i;
    return -1;
  endfunction

  // dly: ACCESS cycle (0-based) in which the target slave raises ready; >= TO never.
  task automatic access(input logic [AW-1:0] a, input int dly, input bit clr);
    int            idx;
    bit            done;
    bit            fault;
    logic [DW-1:0] exp_d;
    idx   = decode(a);
    fault = 1'b1;
    exp_d = '0;
    slv_rdata = {$urandom, $urandom, $urandom, $urandom};
    slv_rdy   = NS'($urandom);
    sel  = 1'b1;
    addr = a;
    @(posedge clk); #1;
    if (idx >= 0) begin
      done = 1'b0;
      for (int c = 0; c < TO && !done; c++) begin
        chk("slv_sel_busy", slv_sel, 64'(1) << idx);
        chk("rdy_busy", rdy, 0);
        chk("trap_busy", trap, 0);
        slv_rdy      = NS'($urandom);
        slv_rdy[idx] = (c == dly);
        if (c == dly) begin
          done  = 1'b1;
          fault = 1'b0;
          exp_d = slv_rdata[idx*DW +: DW];
        end
        @(posedge clk); #1;
      end
    end
    chk("rdy_done", rdy, 1);
    chk("trap_done", trap, fault);
    chk("data_done", data_to_rd, exp_d);
    chk("slv_sel_done", slv_sel, 0);
    sel     = 1'b0;
    slv_rdy = '0;
    err_clr = fault & clr;
    @(posedge clk); #1;
    err_clr = 1'b0;
    if (fault) begin
      if (!m_err || clr) m_err_addr = a;
      m_err = 1'b1;
    end
    chk("rdy_idle", rdy, 0);
    chk("err", err, m_err);
    chk("err_addr", err_addr, m_err_addr);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr    = 1'b0;
    m_err      = 1'b0;
    m_err_addr = '0;
    chk("err_clr", err, 0);
    chk("err_addr_clr", err_addr, 0);
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; addr = '0; slv_rdy = '0; slv_rdata = '0; err_clr = 1'b0;
    #1;
    chk("rst_rdy", rdy, 0);
    chk("rst_trap", trap, 0);
    chk("rst_slv_sel", slv_sel, 0);
    chk("rst_data", data_to_rd, 0);
    chk("rst_err", err, 0);
    chk("rst_err_addr", err_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    access(12'h123, 0, 0);
    access(12'h404, 3, 0);
    access(12'h410, 1, 0);
    access(12'h600, 0, 0);
    access(12'h700, 0, 0);
    access(12'h900, 99, 0);
    access(12'h900, 14, 0);
    access(12'h650, 0, 1);
    clear_err();

    // Async reset in the middle of a stalled access, with err set.
    access(12'h6F0, 0, 0);
    sel = 1'b1; addr = 12'h900; slv_rdy = '0;
    @(posedge clk); #1;
    chk("pre_rst_sel", slv_sel, 4'b1000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    m_err = 1'b0; m_err_addr = '0;
    chk("arst_slv_sel", slv_sel, 0);
    chk("arst_rdy", rdy, 0);
    chk("arst_trap", trap, 0);
    chk("arst_err", err, 0);
    sel = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(12'h123, 2, 0);

    for (int n = 0; n < 60; n++) begin
      access(AW'($urandom), $urandom_range(0, TO + 3), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 7) == 0) clear_err();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
